// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// exception codes that the CP0 block also decodes.
package lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [4:0] LSU_EXC_ADEL = 5'd4;
  localparam logic [4:0] LSU_EXC_ADES = 5'd5;
  localparam logic [4:0] LSU_EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_EXC    = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_align_chk.sv
// Size legality and natural-alignment check for a MIPS memory access.
// Purely combinational so CP0 can reuse it for instruction-fetch AdEL.
module lsu_align_chk
  import lsu_pkg::*;
#(
  parameter logic [4:0] EXC_ADEL = LSU_EXC_ADEL,
  parameter logic [4:0] EXC_ADES = LSU_EXC_ADES
) (
  input  logic       write,
  input  logic [1:0] size,
  input  logic [1:0] addrLo,
  output logic       ok,
  output logic [4:0] excCode
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // if/else chain can leave a value unassigned and infer a latch.
    ok      = 1'b1;
    excCode = write ? EXC_ADES : EXC_ADEL;
    if (size == SZ_ILL) begin
      ok = 1'b0;
    end else if (size == SZ_HALF && addrLo[0]) begin
      ok = 1'b0;
    end else if (size == SZ_WORD && addrLo != 2'b00) begin
      ok = 1'b0;
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store control stage in front of dmem: one request at a time, address
// and size checks, dmem strobes for one cycle, single-cycle response pulse.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [4:0]  EXC_ADEL  = 5'd4,
  parameter logic [4:0]  EXC_ADES  = 5'd5,
  parameter logic [4:0]  EXC_DBE   = 5'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  input  logic        flush,
  output logic        respValid,
  output logic [31:0] respRdata,
  output logic        respExc,
  output logic [4:0]  excCode,
  output logic [31:0] badVAddr,
  output logic        memRead,
  output logic        memWrite,
  output logic [1:0]  lsHB,
  output logic        lU,
  output logic [10:0] addr,
  output logic [31:0] Writedata,
  input  logic [31:0] Readdata
);

  state_e state_q, state_d;

  logic        chk_ok;
  logic [4:0]  chk_exc;
  logic        in_window;
  logic        accept;
  logic        req_ok;
  logic [4:0]  req_exc;

  logic        write_q;
  logic [31:0] vaddr_q;
  logic [4:0]  exc_pend_q;
  logic [10:0] addr_q;
  logic [1:0]  lshb_q;
  logic        lu_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        resp_exc_q;
  logic [4:0]  exc_code_q;
  logic [31:0] bad_vaddr_q;

  lsu_align_chk #(
    .EXC_ADEL (EXC_ADEL),
    .EXC_ADES (EXC_ADES)
  ) u_align_chk (
    .write   (reqWrite),
    .size    (reqSize),
    .addrLo  (reqAddr[1:0]),
    .ok      (chk_ok),
    .excCode (chk_exc)
  );

  // Size/alignment faults take priority over the window check.
  assign in_window = (reqAddr[31:11] == BASE_ADDR[31:11]);
  assign accept    = (state_q == ST_IDLE) && reqValid && !flush;
  assign req_ok    = chk_ok && in_window;
  assign req_exc   = chk_ok ? EXC_DBE : chk_exc;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = req_ok ? ST_ACCESS : ST_EXC;
      ST_ACCESS: state_d = flush ? ST_IDLE : ST_RESP;
      ST_EXC:    state_d = flush ? ST_IDLE : ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Strobes decode from state only; dmem commits a store at the falling edge
  // of ACCESS even if flush or rst ends the cycle.
  always_comb begin
    reqReady  = (state_q == ST_IDLE);
    memRead   = (state_q == ST_ACCESS) && !write_q;
    memWrite  = (state_q == ST_ACCESS) &&  write_q;
    respValid = (state_q == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q     <= 1'b0;
      vaddr_q     <= '0;
      exc_pend_q  <= '0;
      addr_q      <= '0;
      lshb_q      <= '0;
      lu_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_exc_q  <= 1'b0;
      exc_code_q  <= '0;
      bad_vaddr_q <= '0;
    end else begin
      if (accept) begin
        write_q    <= reqWrite;
        vaddr_q    <= reqAddr;
        exc_pend_q <= req_exc;
        // dmem drive only changes for a legal access, so a faulting request
        // leaves the previous addr/lsHB/lU/Writedata in place.
        if (req_ok) begin
          addr_q  <= reqAddr[10:0];
          lshb_q  <= reqSize;
          lu_q    <= reqUnsigned;
          wdata_q <= reqWdata;
        end
      end
      if (state_q == ST_ACCESS && !flush) begin
        rdata_q    <= write_q ? 32'h0 : Readdata;
        resp_exc_q <= 1'b0;
      end
      if (state_q == ST_EXC && !flush) begin
        rdata_q     <= 32'h0;
        resp_exc_q  <= 1'b1;
        exc_code_q  <= exc_pend_q;
        bad_vaddr_q <= vaddr_q;
      end
    end
  end

  assign addr      = addr_q;
  assign lsHB      = lshb_q;
  assign lU        = lu_q;
  assign Writedata = wdata_q;
  assign respRdata = rdata_q;
  assign respExc   = resp_exc_q;
  assign excCode   = exc_code_q;
  assign badVAddr  = bad_vaddr_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a small behavioural dmem model
// (combinational lane-selecting read, falling-edge write).
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqReady, reqWrite, reqUnsigned, flush;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic        respValid, respExc;
  logic [31:0] respRdata, badVAddr;
  logic [4:0]  excCode;
  logic        memRead, memWrite, lU;
  logic [1:0]  lsHB;
  logic [10:0] addr;
  logic [31:0] Writedata, Readdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:511];
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  lsu_mem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqWrite    (reqWrite),
    .reqSize     (reqSize),
    .reqUnsigned (reqUnsigned),
    .reqAddr     (reqAddr),
    .reqWdata    (reqWdata),
    .flush       (flush),
    .respValid   (respValid),
    .respRdata   (respRdata),
    .respExc     (respExc),
    .excCode     (excCode),
    .badVAddr    (badVAddr),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .lsHB        (lsHB),
    .lU          (lU),
    .addr        (addr),
    .Writedata   (Writedata),
    .Readdata    (Readdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (memWrite) begin
      case (lsHB)
        2'b00:   mem[addr[10:2]] <= Writedata;
        2'b01:   mem[addr[10:2]][{addr[1:0], 3'b000} +: 8] <= Writedata[7:0];
        2'b10:   mem[addr[10:2]][{addr[1], 4'b0000} +: 16] <= Writedata[15:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_word = mem[addr[10:2]];
    rd_byte = rd_word[{addr[1:0], 3'b000} +: 8];
    rd_half = rd_word[{addr[1], 4'b0000} +: 16];
    case (lsHB)
      2'b01:   Readdata = lU ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b10:   Readdata = lU ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: Readdata = rd_word;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; on return the DUT is in ACCESS or EXC.
  task automatic send(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
    reqWrite    = w;
    reqSize     = sz;
    reqUnsigned = u;
    reqAddr     = a;
    reqWdata    = d;
    reqValid    = 1'b1;
    step();
    reqValid    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; reqValid = 1'b0; flush = 1'b0;
    reqWrite = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
    reqAddr = '0; reqWdata = '0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[4] = 32'h8000_00F0;
    step();
    step();
    rst = 1'b0;

    check("rst_reqReady",  {31'h0, reqReady},  32'h1);
    check("rst_respValid", {31'h0, respValid}, 32'h0);
    check("rst_memRead",   {31'h0, memRead},   32'h0);
    check("rst_memWrite",  {31'h0, memWrite},  32'h0);
    check("rst_addr",      {21'h0, addr},      32'h0);
    check("rst_Writedata", Writedata,          32'h0);
    check("rst_respRdata", respRdata,          32'h0);
    check("rst_excCode",   {27'h0, excCode},   32'h0);
    check("rst_badVAddr",  badVAddr,           32'h0);

    // lw 0x10
    send(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    check("lw_memRead",   {31'h0, memRead},   32'h1);
    check("lw_memWrite",  {31'h0, memWrite},  32'h0);
    check("lw_addr",      {21'h0, addr},      32'h10);
    check("lw_reqReady",  {31'h0, reqReady},  32'h0);
    check("lw_early_rv",  {31'h0, respValid}, 32'h0);
    step();
    check("lw_respValid", {31'h0, respValid}, 32'h1);
    check("lw_respRdata", respRdata,          32'h8000_00F0);
    check("lw_respExc",   {31'h0, respExc},   32'h0);
    check("lw_memRead_1", {31'h0, memRead},   32'h0);
    step();
    check("lw_rv_drop",   {31'h0, respValid}, 32'h0);
    check("lw_ready_back",{31'h0, reqReady},  32'h1);

    // sb 0x3, then lb / lbu
    send(1'b1, 2'b01, 1'b0, 32'h3, 32'h0000_00A5);
    check("sb_memWrite",  {31'h0, memWrite},  32'h1);
    check("sb_memRead",   {31'h0, memRead},   32'h0);
    check("sb_lsHB",      {30'h0, lsHB},      32'h1);
    check("sb_addr",      {21'h0, addr},      32'h3);
    check("sb_Writedata", Writedata,          32'h0000_00A5);
    step();
    check("sb_respValid", {31'h0, respValid}, 32'h1);
    check("sb_respRdata", respRdata,          32'h0);
    check("sb_memWrite_1",{31'h0, memWrite},  32'h0);
    step();
    send(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
    step();
    check("lb_respRdata", respRdata,          32'hFFFF_FFA5);
    step();
    send(1'b0, 2'b01, 1'b1, 32'h3, 32'h0);
    step();
    check("lbu_respRdata",respRdata,          32'h0000_00A5);
    step();

    // lh at 0x5: misaligned load
    send(1'b0, 2'b10, 1'b0, 32'h5, 32'h0);
    check("lh5_memRead",  {31'h0, memRead},   32'h0);
    check("lh5_memWrite", {31'h0, memWrite},  32'h0);
    check("lh5_addr_hold",{21'h0, addr},      32'h3);
    step();
    check("lh5_respValid",{31'h0, respValid}, 32'h1);
    check("lh5_respExc",  {31'h0, respExc},   32'h1);
    check("lh5_excCode",  {27'h0, excCode},   32'd4);
    check("lh5_badVAddr", badVAddr,           32'h5);
    check("lh5_respRdata",respRdata,          32'h0);
    check("lh5_memRead_1",{31'h0, memRead},   32'h0);
    step();

    // sw at 0x6: misaligned store
    send(1'b1, 2'b00, 1'b0, 32'h6, 32'h1111_2222);
    check("sw6_memWrite", {31'h0, memWrite},  32'h0);
    step();
    check("sw6_respExc",  {31'h0, respExc},   32'h1);
    check("sw6_excCode",  {27'h0, excCode},   32'd5);
    check("sw6_badVAddr", badVAddr,           32'h6);
    step();

    // lw at 0x800: outside the 2 KiB window
    send(1'b0, 2'b00, 1'b0, 32'h0000_0800, 32'h0);
    check("lw800_memRead",{31'h0, memRead},   32'h0);
    step();
    check("lw800_excCode",{27'h0, excCode},   32'd7);
    check("lw800_badVA",  badVAddr,           32'h0000_0800);
    step();

    // illegal size on an out-of-window store: size check wins
    send(1'b1, 2'b11, 1'b0, 32'h0000_0801, 32'h0);
    step();
    check("sz11_respExc", {31'h0, respExc},   32'h1);
    check("sz11_excCode", {27'h0, excCode},   32'd5);
    step();

    // flush during ACCESS of sw 0x20: store commits, no response
    send(1'b1, 2'b00, 1'b0, 32'h20, 32'hDEAD_BEEF);
    check("fl_memWrite",  {31'h0, memWrite},  32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_respValid", {31'h0, respValid}, 32'h0);
    check("fl_reqReady",  {31'h0, reqReady},  32'h1);
    check("fl_mem_word",  mem[8],             32'hDEAD_BEEF);
    step();
    check("fl_respValid2",{31'h0, respValid}, 32'h0);

    // flush together with reqValid in IDLE: not accepted
    reqWrite = 1'b0; reqSize = 2'b00; reqAddr = 32'h10; reqValid = 1'b1; flush = 1'b1;
    step();
    reqValid = 1'b0; flush = 1'b0;
    check("flidle_ready", {31'h0, reqReady},  32'h1);
    check("flidle_memRd", {31'h0, memRead},   32'h0);
    step();
    check("flidle_rv",    {31'h0, respValid}, 32'h0);

    // rst during ACCESS of sw 0x24
    send(1'b1, 2'b00, 1'b0, 32'h24, 32'h1234_5678);
    check("rsta_memWrite",{31'h0, memWrite},  32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rsta_reqReady",{31'h0, reqReady},  32'h1);
    check("rsta_memWrite0",{31'h0, memWrite}, 32'h0);
    check("rsta_respValid",{31'h0, respValid},32'h0);
    check("rsta_addr",    {21'h0, addr},      32'h0);
    check("rsta_Wdata",   Writedata,          32'h0);
    check("rsta_lsHB",    {30'h0, lsHB},      32'h0);
    check("rsta_respExc", {31'h0, respExc},   32'h0);
    check("rsta_excCode", {27'h0, excCode},   32'h0);
    check("rsta_badVA",   badVAddr,           32'h0);
    check("rsta_mem",     mem[9],             32'h1234_5678);

    // following lw completes normally
    send(1'b0, 2'b00, 1'b0, 32'h24, 32'h0);
    check("post_memRead", {31'h0, memRead},   32'h1);
    step();
    check("post_respValid",{31'h0, respValid},32'h1);
    check("post_respRdata",respRdata,         32'h1234_5678);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
